// File: rtl/ieu_scoreboard.sv
// Register scoreboard for the integer execution unit: per-register pending bits and owner
// IDs plus per-unit occupancy counters for the long-latency writers, producing one Decode stall cause.
module ieu_scoreboard #(
    parameter int NREGS  = 32,
    parameter int NUNITS = 4,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 1,
    localparam int UW    = (NUNITS > 1) ? $clog2(NUNITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  IssueD,
    input  logic                  StallD,
    input  logic [UW-1:0]         IssueUnitD,
    input  logic [4:0]            RdD,
    input  logic [4:0]            Rs1D,
    input  logic [4:0]            Rs2D,
    input  logic                  UsesRs1D,
    input  logic                  UsesRs2D,
    input  logic                  ReadsAnyD,
    input  logic [NUNITS-1:0]     DoneW,
    input  logic [NUNITS*5-1:0]   DoneRdW,
    output logic                  ScoreboardStallD,
    output logic [NUNITS-1:0]     UnitFullD,
    output logic [NREGS-1:0]      PendingMask,
    output logic                  ScoreboardErrorM
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [NREGS-1:0]          pend, pend_next;
    logic [NREGS-1:0][UW-1:0]  own, own_next;
    logic [NUNITS-1:0][CW-1:0] cnt, cnt_next;
    logic                      err, err_next;

    logic [NREGS-1:0]  clear_hit;
    logic [NREGS-1:0]  eff_pend;
    logic [NUNITS-1:0] done_ok;
    logic [NUNITS-1:0] full_eff;
    logic              src1_haz, src2_haz, waw_haz, occ_haz;
    logic              accept;

    // A completion only clears a register it actually owns; anything else is a protocol error.
    always_comb begin
        clear_hit = '0;
        done_ok   = '0;
        for (int r = 1; r < NREGS; r++) begin
            for (int u = 0; u < NUNITS; u++) begin
                if (DoneW[u] && pend[r] && DoneRdW[u*5 +: 5] == 5'(r) && own[r] == UW'(u)) begin
                    clear_hit[r] = 1'b1;
                    done_ok[u]   = 1'b1;
                end
            end
        end
        eff_pend = (BYPASS != 0) ? (pend & ~clear_hit) : pend;
    end

    always_comb begin
        full_eff  = '0;
        UnitFullD = '0;
        for (int u = 0; u < NUNITS; u++) begin
            UnitFullD[u] = (cnt[u] == CW'(DEPTH));
            full_eff[u]  = (cnt[u] == CW'(DEPTH))
                         && !(BYPASS != 0 && DoneW[u] && cnt[u] != '0);
        end
    end

    always_comb begin
        src1_haz = 1'b0;
        src2_haz = 1'b0;
        waw_haz  = 1'b0;
        occ_haz  = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (Rs1D == 5'(r) && eff_pend[r]) src1_haz = 1'b1;
            if (Rs2D == 5'(r) && eff_pend[r]) src2_haz = 1'b1;
            if (RdD  == 5'(r) && eff_pend[r]) waw_haz  = 1'b1;
        end
        for (int u = 0; u < NUNITS; u++) begin
            if (IssueUnitD == UW'(u) && full_eff[u]) occ_haz = 1'b1;
        end
    end

    assign ScoreboardStallD = (ReadsAnyD && ((UsesRs1D && src1_haz) || (UsesRs2D && src2_haz)))
                            || (IssueD && (waw_haz || occ_haz));
    assign accept = IssueD && !StallD && !ScoreboardStallD;

    // Clears are applied before the accept's set, so a same-cycle handover keeps the bit with the new owner.
    always_comb begin
        pend_next = pend & ~clear_hit;
        own_next  = own;
        cnt_next  = cnt;
        err_next  = err;
        for (int u = 0; u < NUNITS; u++) begin
            if (DoneW[u]) begin
                if (cnt[u] == '0) err_next = 1'b1;
                else              cnt_next[u] = cnt[u] - 1'b1;
                if (DoneRdW[u*5 +: 5] != 5'd0 && !done_ok[u]) err_next = 1'b1;
            end
        end
        for (int u = 0; u < NUNITS; u++) begin
            if (accept && IssueUnitD == UW'(u)) cnt_next[u] = cnt_next[u] + 1'b1;
        end
        for (int r = 1; r < NREGS; r++) begin
            if (accept && RdD == 5'(r)) begin
                pend_next[r] = 1'b1;
                own_next[r]  = IssueUnitD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
            own  <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            pend <= pend_next;
            own  <= own_next;
            cnt  <= cnt_next;
            err  <= err_next;
        end
    end

    assign PendingMask      = {pend[NREGS-1:1], 1'b0};
    assign ScoreboardErrorM = err;

endmodule
